inst_assembler: RTL and testbench

Sits between program-ROM fetch and the execute stage of the 4004-style core. Accepts a stream of 8-bit program words and classifies each instruction as one or two words. It assembles complete instructions, tags each with the address of its first word, and buffers them in a parametrised queue toward execute. A flush (taken jump/call/return) discards partial and buffered instructions and reloads the fetch address.

---
 rtl/inst_assembler.sv | 150 +++++++++++++++
 tb/tb_inst_assembler.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_assembler.sv
// Instruction assembler for a 4004-style core: groups program words into one- or
// two-word instructions, tags each with its first-word address, and queues them for execute.
module inst_assembler #(
   parameter int                ADDR_W   = 12,
   parameter int                DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [7:0]                   in_word,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic                         flush,
   input  logic [ADDR_W-1:0]            flush_pc,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [1:0]                   out_len,
   output logic [7:0]                   out_w0,
   output logic [7:0]                   out_w1,
   output logic [ADDR_W-1:0]            out_pc,
   output logic [ADDR_W-1:0]            fetch_pc,
   output logic                         partial,
   output logic [$clog2(DEPTH+1)-1:0]   level
);

   localparam int                LVL_W   = $clog2(DEPTH + 1);
   localparam int                PTR_W   = $clog2(DEPTH);
   localparam logic [LVL_W-1:0]  DEPTH_L = LVL_W'(DEPTH);

   typedef enum logic {IDLE, WAIT2} state_e;

   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      logic [1:0]        len;
      logic [7:0]        w0;
      logic [7:0]        w1;
   } entry_t;

   state_e            state_q, state_d;
   logic              partial_q, partial_d;
   logic [7:0]        held_word_q, held_word_d;
   logic [ADDR_W-1:0] held_pc_q, held_pc_d;
   logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
   logic [LVL_W-1:0]  level_q, level_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   entry_t            mem_q [DEPTH];

   logic   accept;
   logic   pop;
   logic   push;
   entry_t push_entry;
   entry_t head;

   // JCN, FIM (even OPA), JUN, JMS and ISZ carry a second word.
   function automatic logic is_two_word(input logic [7:0] w);
      case (w[7:4])
         4'h1, 4'h4, 4'h5, 4'h7: return 1'b1;
         4'h2:                   return ~w[0];
         default:                return 1'b0;
      endcase
   endfunction

   assign in_ready  = !flush && (level_q < DEPTH_L);
   assign out_valid = (level_q != '0) && !flush;
   assign accept    = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   // NOTE: every signal written here gets a default first, so no latch can be inferred.
   always_comb begin
      state_d     = state_q;
      partial_d   = partial_q;
      held_word_d = held_word_q;
      held_pc_d   = held_pc_q;
      fetch_pc_d  = fetch_pc_q;
      level_d     = level_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      push        = 1'b0;
      push_entry  = '0;

      if (flush) begin
         state_d    = IDLE;
         partial_d  = 1'b0;
         fetch_pc_d = flush_pc;
         level_d    = '0;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
      end else begin
         if (accept) begin
            fetch_pc_d = fetch_pc_q + ADDR_W'(1);
            if (state_q == WAIT2) begin
               push       = 1'b1;
               push_entry = '{pc: held_pc_q, len: 2'd2, w0: held_word_q, w1: in_word};
               state_d    = IDLE;
               partial_d  = 1'b0;
            end else if (is_two_word(in_word)) begin
               held_word_d = in_word;
               held_pc_d   = fetch_pc_q;
               state_d     = WAIT2;
               partial_d   = 1'b1;
            end else begin
               push       = 1'b1;
               push_entry = '{pc: fetch_pc_q, len: 2'd1, w0: in_word, w1: 8'h00};
            end
         end
         if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         level_d = level_q + LVL_W'(push) - LVL_W'(pop);
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         partial_q   <= 1'b0;
         held_word_q <= '0;
         held_pc_q   <= '0;
         fetch_pc_q  <= RESET_PC;
         level_q     <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
      end else begin
         state_q     <= state_d;
         partial_q   <= partial_d;
         held_word_q <= held_word_d;
         held_pc_q   <= held_pc_d;
         fetch_pc_q  <= fetch_pc_d;
         level_q     <= level_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
      end
   end

   // NOTE: queue storage is not reset; an empty queue forces the visible head to zero instead.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= push_entry;
   end

   assign head     = (level_q != '0) ? mem_q[rd_ptr_q] : '0;
   assign out_pc   = head.pc;
   assign out_len  = head.len;
   assign out_w0   = head.w0;
   assign out_w1   = head.w1;
   assign fetch_pc = fetch_pc_q;
   assign partial  = partial_q;
   assign level    = level_q;

endmodule

// File: tb/tb_inst_assembler.sv
// Bench for inst_assembler: a queue-based instruction model checked every cycle,
// plus literal expectations on the instruction stream the model delivers.
module tb_inst_assembler;

   localparam int         AW       = 12;
   localparam int         DEPTH    = 4;
   localparam logic [11:0] RESET_PC = 12'h000;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [7:0]    in_word;
   logic          in_valid;
   logic          in_ready;
   logic          flush;
   logic [AW-1:0] flush_pc;
   logic          out_valid;
   logic          out_ready;
   logic [1:0]    out_len;
   logic [7:0]    out_w0;
   logic [7:0]    out_w1;
   logic [AW-1:0] out_pc;
   logic [AW-1:0] fetch_pc;
   logic          partial;
   logic [2:0]    level;

   inst_assembler #(.ADDR_W(AW), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk(clk), .rst_n(rst_n), .in_word(in_word), .in_valid(in_valid), .in_ready(in_ready),
      .flush(flush), .flush_pc(flush_pc), .out_valid(out_valid), .out_ready(out_ready),
      .out_len(out_len), .out_w0(out_w0), .out_w1(out_w1), .out_pc(out_pc),
      .fetch_pc(fetch_pc), .partial(partial), .level(level)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [AW-1:0] pc;
      int            len;
      logic [7:0]    w0;
      logic [7:0]    w1;
   } ins_t;

   ins_t          mq[$];
   ins_t          seen[$];
   bit            m_partial = 1'b0;
   logic [7:0]    m_hw      = 8'h00;
   logic [AW-1:0] m_hpc     = '0;
   logic [AW-1:0] m_fetch   = RESET_PC;
   bit            m_acc     = 1'b0;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit two_word(input logic [7:0] w);
      int op;
      op = int'(w[7:4]);
      if (op == 1 || op == 4 || op == 5 || op == 7) return 1'b1;
      if (op == 2) return (w[0] == 1'b0);
      return 1'b0;
   endfunction

   // Instruction-level model: one step per rising edge, from the inputs held during the cycle.
   task automatic model_step();
      bit   acc;
      bit   do_pop;
      ins_t e;
      m_acc = 1'b0;
      if (!rst_n) begin
         mq.delete();
         m_partial = 1'b0;
         m_fetch   = RESET_PC;
         return;
      end
      if (flush) begin
         mq.delete();
         m_partial = 1'b0;
         m_fetch   = flush_pc;
         return;
      end
      acc    = in_valid && (mq.size() < DEPTH);
      do_pop = (mq.size() != 0) && out_ready;
      if (do_pop) begin
         e = mq.pop_front();
         seen.push_back(e);
      end
      if (acc) begin
         m_acc = 1'b1;
         if (m_partial) begin
            mq.push_back('{pc: m_hpc, len: 2, w0: m_hw, w1: in_word});
            m_partial = 1'b0;
         end else if (two_word(in_word)) begin
            m_hw      = in_word;
            m_hpc     = m_fetch;
            m_partial = 1'b1;
         end else begin
            mq.push_back('{pc: m_fetch, len: 1, w0: in_word, w1: 8'h00});
         end
         m_fetch = m_fetch + 12'd1;
      end
   endtask

   task automatic compare();
      bit exp_valid;
      exp_valid = (mq.size() != 0) && !flush;
      check("out_valid", 32'(out_valid), 32'(exp_valid));
      check("in_ready",  32'(in_ready),  32'(!flush && (mq.size() < DEPTH)));
      check("level",     32'(level),     32'(mq.size()));
      check("partial",   32'(partial),   32'(m_partial));
      check("fetch_pc",  32'(fetch_pc),  32'(m_fetch));
      if (exp_valid && out_valid) begin
         check("out_pc",  32'(out_pc),  32'(mq[0].pc));
         check("out_len", 32'(out_len), 32'(mq[0].len));
         check("out_w0",  32'(out_w0),  32'(mq[0].w0));
         check("out_w1",  32'(out_w1),  32'(mq[0].w1));
      end
   endtask

   initial begin
      forever begin
         @(posedge clk);
         model_step();
         #2;
         compare();
      end
   end

   task automatic drive_word(input logic [7:0] w);
      @(negedge clk);
      in_word  = w;
      in_valid = 1'b1;
   endtask

   task automatic wait_accept(input int budget);
      int n;
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!m_acc && n < budget);
      if (!m_acc) check("accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic send_word(input logic [7:0] w);
      drive_word(w);
      wait_accept(20);
   endtask

   task automatic idle(input int cycles);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (cycles) @(negedge clk);
   endtask

   task automatic set_ready(input logic r);
      @(negedge clk);
      out_ready = r;
   endtask

   task automatic do_flush(input logic [AW-1:0] pc);
      @(negedge clk);
      in_valid = 1'b0;
      flush    = 1'b1;
      flush_pc = pc;
      @(negedge clk);
      flush    = 1'b0;
   endtask

   task automatic expect_ins(input int idx, input logic [AW-1:0] pc, input int len,
                             input logic [7:0] w0, input logic [7:0] w1);
      if (idx >= seen.size()) begin
         check("seen_missing", 32'(seen.size()), 32'(idx + 1));
      end else begin
         check("seen_pc",  32'(seen[idx].pc),  32'(pc));
         check("seen_len", 32'(seen[idx].len), 32'(len));
         check("seen_w0",  32'(seen[idx].w0),  32'(w0));
         check("seen_w1",  32'(seen[idx].w1),  32'(w1));
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      in_word   = 8'h00;
      in_valid  = 1'b0;
      flush     = 1'b0;
      flush_pc  = '0;
      out_ready = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_level",     32'(level),     32'd0);
      check("rst_partial",   32'(partial),   32'd0);
      check("rst_fetch_pc",  32'(fetch_pc),  32'h000);
      check("rst_out_data",  32'({out_pc, out_len, out_w0, out_w1}), 32'd0);
      rst_n = 1'b1;

      // Mixed stream at full rate.
      set_ready(1'b1);
      send_word(8'hD5);
      send_word(8'h40);
      send_word(8'h23);
      send_word(8'hF2);
      idle(4);
      check("stream_count", 32'(seen.size()), 32'd3);
      expect_ins(0, 12'h000, 1, 8'hD5, 8'h00);
      expect_ins(1, 12'h001, 2, 8'h40, 8'h23);
      expect_ins(2, 12'h003, 1, 8'hF2, 8'h00);
      check("stream_fetch_pc", 32'(fetch_pc), 32'h004);
      seen.delete();

      // Backpressure: queue fills, fifth word waits.
      set_ready(1'b0);
      for (int i = 0; i < 4; i++) send_word(8'hD0 + 8'(i));
      drive_word(8'hD4);
      repeat (3) @(posedge clk);
      #1;
      check("full_level",    32'(level),    32'd4);
      check("full_in_ready", 32'(in_ready), 32'd0);
      check("full_no_accept", 32'(m_acc),   32'd0);
      set_ready(1'b1);
      wait_accept(10);
      idle(6);
      check("full_count", 32'(seen.size()), 32'd5);
      for (int i = 0; i < 5; i++)
         expect_ins(i, 12'h004 + 12'(i), 1, 8'hD0 + 8'(i), 8'h00);
      seen.delete();

      // Two-word instruction with an input gap.
      send_word(8'h12);
      idle(3);
      check("gap_partial", 32'(partial), 32'd1);
      check("gap_no_out",  32'(out_valid), 32'd0);
      send_word(8'h34);
      idle(3);
      check("gap_count", 32'(seen.size()), 32'd1);
      expect_ins(0, 12'h009, 2, 8'h12, 8'h34);
      seen.delete();

      // Odd OPA on opcode 2 is one word; even OPA is FIM.
      send_word(8'h21);
      send_word(8'h20);
      send_word(8'h55);
      idle(3);
      check("fim_count", 32'(seen.size()), 32'd2);
      expect_ins(0, 12'h00B, 1, 8'h21, 8'h00);
      expect_ins(1, 12'h00C, 2, 8'h20, 8'h55);
      seen.delete();

      // Flush with two queued entries and a held first word.
      set_ready(1'b0);
      send_word(8'hD0);
      send_word(8'hD1);
      send_word(8'h40);
      idle(1);
      check("pre_flush_level",   32'(level),   32'd2);
      check("pre_flush_partial", 32'(partial), 32'd1);
      do_flush(12'h3A0);
      #1;
      check("flush_out_valid", 32'(out_valid), 32'd0);
      check("flush_level",     32'(level),     32'd0);
      check("flush_partial",   32'(partial),   32'd0);
      check("flush_fetch_pc",  32'(fetch_pc),  32'h3A0);
      set_ready(1'b1);
      send_word(8'hD1);
      idle(3);
      check("flush_count", 32'(seen.size()), 32'd1);
      expect_ins(0, 12'h3A0, 1, 8'hD1, 8'h00);
      seen.delete();

      // Two-word instruction across the address wrap.
      do_flush(12'hFFF);
      send_word(8'h40);
      send_word(8'h00);
      idle(3);
      check("wrap_count", 32'(seen.size()), 32'd1);
      expect_ins(0, 12'hFFF, 2, 8'h40, 8'h00);
      check("wrap_fetch_pc", 32'(fetch_pc), 32'h001);
      seen.delete();

      // Asynchronous reset with data queued and a partial instruction held.
      set_ready(1'b0);
      send_word(8'hD0);
      send_word(8'h40);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("arst_out_valid", 32'(out_valid), 32'd0);
      check("arst_level",     32'(level),     32'd0);
      check("arst_partial",   32'(partial),   32'd0);
      check("arst_fetch_pc",  32'(fetch_pc),  32'h000);
      check("arst_out_data",  32'({out_pc, out_len, out_w0, out_w1}), 32'd0);
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
